dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_pkg.sv | 42 ++++
 rtl/dm_arb_pick.sv | 47 ++++
 rtl/dm_arbiter.sv | 124 ++++++++++++
 tb/tb_dm_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory arbiter.
//   - DMCtrl width codes (loads and stores share the width encoding;
//     the direction comes from the separate write flag)
//   - arbiter FSM state enum
//   - latched request record
//   - size-from-ctrl and ctrl-validity helpers
package dm_pkg;

  localparam logic [2:0] LB   = 3'b000;
  localparam logic [2:0] LH   = 3'b001;
  localparam logic [2:0] LW   = 3'b010;
  localparam logic [2:0] LB_U = 3'b100;
  localparam logic [2:0] LH_U = 3'b101;
  localparam logic [2:0] SB   = 3'b000;
  localparam logic [2:0] SH   = 3'b001;
  localparam logic [2:0] SW   = 3'b010;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} dm_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic [2:0]  ctrl;
  } dm_req_t;

  // Access size in bytes; 0 for the reserved width code 11.
  function automatic logic [2:0] dm_size(input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // 011 and 11x are not legal width codes.
  function automatic logic dm_ctrl_ok(input logic [2:0] ctrl);
    return (ctrl[1:0] != 2'b11) && !(ctrl[2] && ctrl[1]);
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// dm_arb_pick: combinational grant selection.
//   i_req  [NREQ-1:0] request vector
//   i_ptr  [IDXW-1:0] last granted index (round-robin build only)
//   o_gnt  [NREQ-1:0] one-hot grant (all zero when no request)
//   o_idx  [IDXW-1:0] index of the granted requester
// Macro DM_ARB_RR_EN: defined -> round-robin starting after i_ptr;
// undefined -> fixed priority, lowest index wins, i_ptr ignored.
module dm_arb_pick #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDXW-1:0] o_idx
);

`ifdef DM_ARB_RR_EN
  // Walk from farthest to nearest so the port right after i_ptr
  // is the last (winning) assignment.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (i_req[(int'(i_ptr) + k) % NREQ]) begin
        o_gnt = NREQ'(1) << ((int'(i_ptr) + k) % NREQ);
        o_idx = IDXW'((int'(i_ptr) + k) % NREQ);
      end
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_gnt = NREQ'(1) << k;
        o_idx = IDXW'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data-memory port between NREQ requesters
// (port 0 core LSU, port 1 loader/DMA). One access per 3 cycles:
// IDLE (grant + latch) -> ACCESS (memory cycle) -> RESP (Ack pulse).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   Req/ReqAddr/ReqData/ReqWr/ReqCtrl   per-requester request
//   Ack, Err              one-cycle completion / out-of-range flag
//   RdData                registered load result (0 on error/invalid)
//   Address/DataWr/DMWr/DMCtrl, DataRd  memory side
// Macro DM_ARB_RR_EN: round-robin arbitration (default: fixed priority).
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int MEM_BYTES = 8192,
  parameter int NREQ      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ-1:0][31:0] ReqAddr,
  input  logic [NREQ-1:0][31:0] ReqData,
  input  logic [NREQ-1:0]       ReqWr,
  input  logic [NREQ-1:0][2:0]  ReqCtrl,
  output logic [NREQ-1:0]       Ack,
  output logic [NREQ-1:0]       Err,
  output logic [31:0]           RdData,
  output logic [31:0]           Address,
  output logic [31:0]           DataWr,
  output logic                  DMWr,
  output logic [2:0]            DMCtrl,
  input  logic [31:0]           DataRd
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  dm_state_e       r_state, w_next;
  dm_req_t         r_req;
  logic [NREQ-1:0] r_gnt, w_gnt;
  logic [IDXW-1:0] w_idx, w_ptr;
  logic            r_err;
  logic [31:0]     r_rdata;
  logic [32:0]     w_end;
  logic            w_ok, w_oor, w_hit;

`ifdef DM_ARB_RR_EN
  logic [IDXW-1:0] r_last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_last <= IDXW'(NREQ - 1);
    else if (r_state == IDLE && |Req)   r_last <= w_idx;
  end
  assign w_ptr = r_last;
`else
  assign w_ptr = '0;
`endif

  dm_arb_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .i_req (Req),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  // Last byte touched, 33 bits so addresses near 2^32 cannot wrap in range.
  assign w_end = {1'b0, r_req.addr} + 33'(dm_size(r_req.ctrl)) - 33'd1;
  assign w_ok  = dm_ctrl_ok(r_req.ctrl);
  assign w_oor = w_ok && (w_end >= 33'(MEM_BYTES));
  assign w_hit = w_ok && !w_oor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|Req) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch and access result. Memory-side fields only change on a
  // grant, so they are stable around every memory write edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= '{addr: '0, data: '0, wr: 1'b0, ctrl: LW};
      r_gnt   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (|Req) begin
          r_req <= '{addr: ReqAddr[w_idx], data: ReqData[w_idx],
                     wr: ReqWr[w_idx], ctrl: ReqCtrl[w_idx]};
          r_gnt <= w_gnt;
        end
        ACCESS: begin
          r_err <= w_oor;
          if (!w_hit)          r_rdata <= '0;
          else if (!r_req.wr)  r_rdata <= DataRd;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Ack     = '0;
    Err     = '0;
    DMWr    = 1'b0;
    if (r_state == RESP) begin
      Ack = r_gnt;
      if (r_err) Err = r_gnt;
    end
    if (r_state == ACCESS) DMWr = r_req.wr && w_hit;
    RdData  = r_rdata;
    Address = r_req.addr;
    DataWr  = r_req.data;
    DMCtrl  = r_req.ctrl;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized + directed self-check of dm_arbiter against a
// byte-array reference memory. The bench memory sign/zero-extends per
// DMCtrl and returns junk for invalid codes / bytes past the end so the
// arbiter's zeroing is visible.
module tb_dm_arbiter;
  import dm_pkg::*;

  localparam int MEM_BYTES = 8192;
  localparam int NREQ      = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       Req = '0;
  logic [NREQ-1:0][31:0] ReqAddr = '0;
  logic [NREQ-1:0][31:0] ReqData = '0;
  logic [NREQ-1:0]       ReqWr = '0;
  logic [NREQ-1:0][2:0]  ReqCtrl = '0;
  logic [NREQ-1:0]       Ack, Err;
  logic [31:0]           RdData, Address, DataWr, DataRd;
  logic                  DMWr;
  logic [2:0]            DMCtrl;

  always #5 clk = ~clk;

  dm_arbiter #(.MEM_BYTES(MEM_BYTES), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .Req(Req), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .ReqWr(ReqWr), .ReqCtrl(ReqCtrl), .Ack(Ack), .Err(Err), .RdData(RdData),
    .Address(Address), .DataWr(DataWr), .DMWr(DMWr), .DMCtrl(DMCtrl),
    .DataRd(DataRd)
  );

  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  logic       pl_en = 1'b0;
  int         n_wr = 0;
  int         n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [7:0] b0, b1, b2, b3, input logic [2:0] c);
    case (c)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b010:  return {b3, b2, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] c);
    return (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Bench memory: combinational read, write on the rising edge.
  always_comb begin
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++)
      b[i] = ({1'b0, Address} + 33'(i) < 33'(MEM_BYTES)) ? mem[Address[12:0] + 13'(i)] : 8'hEE;
    DataRd = ext(b[0], b[1], b[2], b[3], DMCtrl);
  end

  always @(posedge clk) begin
    if (pl_en) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= ref_mem[i];
    end else if (DMWr) begin
      n_wr <= n_wr + 1;
      for (int i = 0; i < nbytes(DMCtrl); i++)
        mem[Address[12:0] + 13'(i)] <= DataWr[8*i +: 8];
    end
  end

  // Issue one request on port p and check it against the reference model.
  task automatic do_access(input int p, input logic [31:0] a, input logic [31:0] d,
                           input logic w, input logic [2:0] c, input bit drop_early,
                           output logic [31:0] rd_o);
    bit              valid, oor;
    longint          last;
    logic [31:0]     exp_rd;
    logic [NREQ-1:0] ack_s, err_s;
    int              lat, wr0;
    valid  = !(c inside {3'b011, 3'b110, 3'b111});
    last   = longint'(a) + nbytes(c) - 1;
    oor    = valid && (last >= MEM_BYTES);
    exp_rd = 32'h0;
    if (valid && !oor && !w)
      exp_rd = ext(ref_mem[a], (nbytes(c) > 1) ? ref_mem[a+1] : 8'h0,
                   (nbytes(c) > 2) ? ref_mem[a+2] : 8'h0,
                   (nbytes(c) > 2) ? ref_mem[a+3] : 8'h0, c);
    @(negedge clk);
    Req[p] = 1'b1; ReqAddr[p] = a; ReqData[p] = d; ReqWr[p] = w; ReqCtrl[p] = c;
    wr0 = n_wr; lat = 0; ack_s = '0; err_s = '0; rd_o = '0;
    while (lat < 8 && ack_s == '0) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (drop_early && lat == 1) Req[p] = 1'b0;
      ack_s = Ack; err_s = Err; rd_o = RdData;
    end
    Req[p] = 1'b0;
    chk("latency", lat, 2);
    chk("ack", 32'(ack_s), 32'(1 << p));
    chk("err", 32'(err_s), oor ? 32'(1 << p) : 32'h0);
    if (!w) chk("rddata", rd_o, exp_rd);
    chk("dmwr_count", n_wr - wr0, (w && valid && !oor) ? 1 : 0);
    if (w && valid && !oor)
      for (int i = 0; i < nbytes(c); i++) ref_mem[a + i] = d[8*i +: 8];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    logic [2:0]  c;
    logic        w;
    int          k, sel, bad;
    logic [NREQ-1:0] acc;

    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
    ref_mem[16] = 8'hEF; ref_mem[17] = 8'hBE; ref_mem[18] = 8'hAD; ref_mem[19] = 8'hDE;
    pl_en = 1'b1;
    repeat (2) @(negedge clk);
    pl_en = 1'b0;
    @(negedge clk);
    chk("rst_ack", 32'(Ack), 0);
    chk("rst_err", 32'(Err), 0);
    chk("rst_rddata", RdData, 0);
    chk("rst_dmwr", 32'(DMWr), 0);
    chk("rst_addr", Address, 0);
    chk("rst_datawr", DataWr, 0);
    chk("rst_dmctrl", 32'(DMCtrl), 32'h2);
    rst_n = 1'b1;

    // single LW load
    do_access(0, 32'h10, 32'h0, 1'b0, LW, 1'b0, rd);
    chk("lw_deadbeef", rd, 32'hDEADBEEF);

    // SB then signed LB from port 1
    do_access(1, 32'h20, 32'hA5, 1'b1, SB, 1'b0, rd);
    do_access(1, 32'h20, 32'h0, 1'b0, LB, 1'b0, rd);
    chk("lb_signext", rd, 32'hFFFFFFA5);

    // SW straddling the end of memory
    do_access(0, 32'h1FFE, 32'h11223344, 1'b1, SW, 1'b0, rd);
    chk("range_mem", {16'h0, mem[8191], mem[8190]}, {16'h0, ref_mem[8191], ref_mem[8190]});

    // contention, both ports continuously requesting
    @(negedge clk);
    Req = '1;
    ReqAddr[0] = 32'h10; ReqWr[0] = 1'b0; ReqCtrl[0] = LW;
    ReqAddr[1] = 32'h20; ReqWr[1] = 1'b0; ReqCtrl[1] = LW;
    k = 0;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk); @(negedge clk);
      if (Ack != '0) begin
`ifdef DM_ARB_RR_EN
        chk("cont_gnt", 32'(Ack), 32'(1 << (k % 2)));
`else
        chk("cont_gnt", 32'(Ack), 32'h1);
`endif
        chk("cont_time", t, 2 + 3 * k);
        k++;
      end
    end
    Req = '0;
    chk("cont_count", k, 4);

    // reset in the ACCESS cycle of a SW
    @(negedge clk);
    Req[0] = 1'b1; ReqAddr[0] = 32'h40; ReqData[0] = 32'h12345678;
    ReqWr[0] = 1'b1; ReqCtrl[0] = SW;
    @(posedge clk); #1;
    chk("abort_dmwr_pre", 32'(DMWr), 1);
    Req[0] = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("abort_dmwr_drop", 32'(DMWr), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acc = '0;
    repeat (6) begin
      @(negedge clk);
      acc |= Ack;
    end
    chk("abort_no_ack", 32'(acc), 0);
    chk("abort_mem", {mem[67], mem[66], mem[65], mem[64]},
        {ref_mem[67], ref_mem[66], ref_mem[65], ref_mem[64]});
    do_access(1, 32'h40, 32'h0, 1'b0, LW, 1'b0, rd);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 7);
      a = (sel < 5) ? 32'($urandom_range(0, 63)) :
          (sel < 7) ? 32'(MEM_BYTES - 4 + $urandom_range(0, 5)) : $urandom;
      c = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      do_access($urandom_range(0, 1), a, $urandom, w, c, $urandom_range(0, 3) == 0, rd);
    end

    @(negedge clk);
    bad = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
